// File: rtl/key_conditioner_pkg.sv
// rtl/key_conditioner_pkg.sv - shared types and defaults for the key conditioner
//
// Purpose: per-channel debounce state encoding and the default debounce length
// used by key_debounce and key_conditioner. No ports.
package key_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } key_state_t;

  localparam int DEFAULT_DEBOUNCE = 4;

endpackage

// File: rtl/key_conditioner_debounce.sv
// rtl/key_conditioner_debounce.sv - one key channel: synchroniser, debounce FSM, press pulse
//
// Purpose: turns one raw active-low key into a single-cycle pulse per accepted press.
// Ports:
//   clk    in  1  system clock, posedge
//   Reset  in  1  asynchronous active-low reset
//   key_n  in  1  raw key, 0 = pressed, asynchronous to clk
//   pulse  out 1  registered one-cycle pulse on entry to HELD
//   state  out 2  registered channel state (used by the top for new-game gating)
module key_debounce
  import key_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       key_n,
  output logic       pulse,
  output key_state_t state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2;
  key_state_t    state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          pulse_q, pulse_n;

  // Synchroniser resets to "pressed" and the FSM to HELD, so a key held
  // through reset release must be released and pressed again to count.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      state_q <= HELD;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      s1      <= ~key_n;
      s2      <= s1;
      state_q <= state_n;
      cnt_q   <= cnt_n;
      pulse_q <= pulse_n;
    end
  end

  // cnt counts stable samples already seen in the current wait state;
  // the sample that makes it DEBOUNCE_CYCLES completes the wait.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    pulse_n = 1'b0;
    case (state_q)
      IDLE: begin
        if (s2) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_n = HELD;
            cnt_n   = '0;
            pulse_n = 1'b1;
          end else begin
            state_n = PRESS_WAIT;
            cnt_n   = CW'(1);
          end
        end
      end
      PRESS_WAIT: begin
        if (!s2) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt_q == LAST) begin
          state_n = HELD;
          cnt_n   = '0;
          pulse_n = 1'b1;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!s2) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            state_n = REL_WAIT;
            cnt_n   = CW'(1);
          end
        end
      end
      REL_WAIT: begin
        if (s2) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (cnt_q == LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign pulse = pulse_q;
  assign state = state_q;

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - three debounced key channels with new-game gating of L/R
//
// Purpose: clean single-cycle L, R and newGame pulses from raw active-low keys.
// Ports:
//   clk      in  1  system clock, posedge
//   Reset    in  1  asynchronous active-low reset
//   keyL_n   in  1  raw left key, 0 = pressed
//   keyR_n   in  1  raw right key, 0 = pressed
//   keyNG_n  in  1  raw new-game key, 0 = pressed
//   L        out 1  left press pulse, suppressed while new game is active
//   R        out 1  right press pulse, suppressed while new game is active
//   newGame  out 1  new-game press pulse
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic clk,
  input  logic Reset,
  input  logic keyL_n,
  input  logic keyR_n,
  input  logic keyNG_n,
  output logic L,
  output logic R,
  output logic newGame
);

  logic       l_pulse, r_pulse, ng_pulse;
  key_state_t l_state, r_state, ng_state;
  logic       ng_busy;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk   (clk),
    .Reset (Reset),
    .key_n (keyL_n),
    .pulse (l_pulse),
    .state (l_state)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk   (clk),
    .Reset (Reset),
    .key_n (keyR_n),
    .pulse (r_pulse),
    .state (r_state)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_newgame (
    .clk   (clk),
    .Reset (Reset),
    .key_n (keyNG_n),
    .pulse (ng_pulse),
    .state (ng_state)
  );

  // Gating looks only at registered new-game state, so there is no path
  // from the raw keys to L/R. The L/R channels keep running underneath.
  assign ng_busy = (ng_state == HELD) || (ng_state == REL_WAIT) || ng_pulse;

  // A valid pulse is only ever present in its channel's HELD state;
  // qualifying on it keeps a stray pulse bit from escaping.
  assign L       = l_pulse & (l_state == HELD) & ~ng_busy;
  assign R       = r_pulse & (r_state == HELD) & ~ng_busy;
  assign newGame = ng_pulse;

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - scoreboard bench for key_conditioner
module tb_key_conditioner;

  localparam int D = 4;

  typedef struct packed {
    logic [2:0] v;
    int         c;
  } ev_t;

  logic clk = 1'b0;
  logic Reset = 1'b1;
  logic keyL_n = 1'b1;
  logic keyR_n = 1'b1;
  logic keyNG_n = 1'b1;
  logic L, R, newGame;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  ev_t  obs_q[$];

  key_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk     (clk),
    .Reset   (Reset),
    .keyL_n  (keyL_n),
    .keyR_n  (keyR_n),
    .keyNG_n (keyNG_n),
    .L       (L),
    .R       (R),
    .newGame (newGame)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // cyc at a negedge equals the number of posedges so far
  always @(negedge clk) begin
    if ((L | R | newGame) === 1'b1)
      obs_q.push_back(ev_t'{v: {L, R, newGame}, c: cyc});
  end

  // press applied at negedge with count c -> first edge is c+1 -> pulse after edge c+1+1+D
  function automatic int pulse_edge(input int c);
    return c + 2 + D;
  endfunction

  task automatic test_reset();
    int c;
    keyL_n = 1'b0;
    #1 Reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (L !== 1'b0) begin errors++; $display("FAIL reset_L: got %b, expected 0", L); end
    checks++; if (R !== 1'b0) begin errors++; $display("FAIL reset_R: got %b, expected 0", R); end
    checks++; if (newGame !== 1'b0) begin errors++; $display("FAIL reset_newGame: got %b, expected 0", newGame); end
    Reset = 1'b1;
    repeat (20) @(negedge clk);
    keyL_n = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (obs_q.size() !== 0) begin
      errors++; $display("FAIL reset_held_nopulse: got %0d pulses, expected 0", obs_q.size());
    end
    obs_q.delete();
    c = cyc;
    keyL_n = 1'b0;
    exp_q.push_back(ev_t'{v: 3'b100, c: pulse_edge(c)});
    repeat (12) @(negedge clk);
    keyL_n = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL reset_fresh_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL reset_fresh_event%0d: got LRN=%b at edge %0d, expected LRN=%b at edge %0d", i, obs_q[i].v, obs_q[i].c, exp_q[i].v, exp_q[i].c);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_clean_press();
    int c;
    c = cyc;
    keyR_n = 1'b0;
    exp_q.push_back(ev_t'{v: 3'b010, c: pulse_edge(c)});
    repeat (30) @(negedge clk);
    keyR_n = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL clean_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL clean_event%0d: got LRN=%b at edge %0d, expected LRN=%b at edge %0d", i, obs_q[i].v, obs_q[i].c, exp_q[i].v, exp_q[i].c);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    pat = 5'b10100;
    for (int i = 0; i < 5; i++) begin
      keyL_n = pat[i];
      @(negedge clk);
    end
    exp_q.push_back(ev_t'{v: 3'b100, c: pulse_edge(cyc)});
    keyL_n = 1'b0;
    repeat (20) @(negedge clk);
    keyL_n = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL bounce_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bounce_event%0d: got LRN=%b at edge %0d, expected LRN=%b at edge %0d", i, obs_q[i].v, obs_q[i].c, exp_q[i].v, exp_q[i].c);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_simultaneous();
    int c;
    c = cyc;
    keyL_n = 1'b0;
    keyR_n = 1'b0;
    exp_q.push_back(ev_t'{v: 3'b110, c: pulse_edge(c)});
    repeat (12) @(negedge clk);
    keyL_n = 1'b1;
    keyR_n = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL simul_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL simul_event%0d: got LRN=%b at edge %0d, expected LRN=%b at edge %0d", i, obs_q[i].v, obs_q[i].c, exp_q[i].v, exp_q[i].c);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_newgame_gating();
    int c;
    c = cyc;
    keyNG_n = 1'b0;
    exp_q.push_back(ev_t'{v: 3'b001, c: pulse_edge(c)});
    repeat (10) @(negedge clk);
    keyL_n = 1'b0;
    repeat (8) @(negedge clk);
    keyL_n = 1'b1;
    repeat (10) @(negedge clk);
    keyNG_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL gating_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL gating_event%0d: got LRN=%b at edge %0d, expected LRN=%b at edge %0d", i, obs_q[i].v, obs_q[i].c, exp_q[i].v, exp_q[i].c);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_async_reset();
    int c;
    bit found;
    c = cyc;
    keyR_n = 1'b0;
    exp_q.push_back(ev_t'{v: 3'b010, c: pulse_edge(c)});
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (R === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL async_wait_R: got no R pulse within 20 cycles, expected one"); end
    #1 Reset = 1'b0;
    #1;
    checks++;
    if (R !== 1'b0) begin errors++; $display("FAIL async_R_drop: got %b, expected 0 before next clock", R); end
    repeat (3) @(negedge clk);
    Reset = 1'b1;
    repeat (20) @(negedge clk);
    keyR_n = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL async_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL async_event%0d: got LRN=%b at edge %0d, expected LRN=%b at edge %0d", i, obs_q[i].v, obs_q[i].c, exp_q[i].v, exp_q[i].c);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_newgame_gating();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
